// File: rtl/bus_bridge.sv
// bus_bridge: responder end of the single-cycle CPU data bus.
// Routes each Bus_* access either to the data DRAM or to the on-chip
// peripheral registers (digital-tube data, timer, LEDs, switches, buttons).
// Reads are combinational. Writes commit on the rising edge of cpu_clk.
//
// Ports:
//   cpu_clk     system clock
//   cpu_rst     asynchronous active-low reset
//   Bus_addr    byte address from the CPU
//   Bus_wen     write strobe (one word per cycle)
//   Bus_wdata   write data
//   Bus_rdata   combinational read data for Bus_addr
//   dram_addr   DRAM word address (Bus_addr[15:2])
//   dram_wen    DRAM write enable, suppressed for peripheral accesses
//   dram_wdata  DRAM write data (Bus_wdata)
//   dram_rdata  DRAM combinational read data
//   sw, btn     raw asynchronous board switches / buttons
//   led         LED register
//   seg_data    digital-tube display word
module bus_bridge #(
    parameter logic [31:0] TIMER_DIV_RST = 32'd0
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] Bus_addr,
    input  logic        Bus_wen,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] Bus_rdata,
    output logic [13:0] dram_addr,
    output logic        dram_wen,
    output logic [31:0] dram_wdata,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  btn,
    output logic [23:0] led,
    output logic [31:0] seg_data
);

    localparam logic [11:0] OFF_SEG  = 12'h000;
    localparam logic [11:0] OFF_TCNT = 12'h020;
    localparam logic [11:0] OFF_TDIV = 12'h024;
    localparam logic [11:0] OFF_LED  = 12'h060;
    localparam logic [11:0] OFF_SW   = 12'h070;
    localparam logic [11:0] OFF_BTN  = 12'h078;

    logic        periph_hit;
    logic [11:0] off;
    logic        wr_seg, wr_tcnt, wr_tdiv, wr_led;

    logic [31:0] tcnt;
    logic [31:0] tdiv;
    logic [31:0] pre;
    logic [31:0] tdiv_eff;
    logic        tick;

    logic [23:0] sw_meta, sw_sync;
    logic [4:0]  btn_meta, btn_sync;

    logic [31:0] periph_rdata;

    assign periph_hit = (Bus_addr[31:12] == 20'hFFFFF);
    assign off        = Bus_addr[11:0];

    assign dram_addr  = Bus_addr[15:2];
    assign dram_wen   = Bus_wen & ~periph_hit;
    assign dram_wdata = Bus_wdata;

    assign wr_seg  = Bus_wen & periph_hit & (off == OFF_SEG);
    assign wr_tcnt = Bus_wen & periph_hit & (off == OFF_TCNT);
    assign wr_tdiv = Bus_wen & periph_hit & (off == OFF_TDIV);
    assign wr_led  = Bus_wen & periph_hit & (off == OFF_LED);

    // A divisor of zero is treated as one so the timer never stalls.
    assign tdiv_eff = (tdiv == '0) ? 32'd1 : tdiv;
    assign tick     = (pre == tdiv_eff - 32'd1);

    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            seg_data <= '0;
            led      <= '0;
        end else begin
            if (wr_seg) seg_data <= Bus_wdata;
            if (wr_led) led      <= Bus_wdata[23:0];
        end
    end

    // Timer. A TCNT write overrides a coincident tick; a TDIV write restarts
    // the prescaler but a tick decided by the old divisor still counts.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            pre  <= '0;
            tcnt <= '0;
            tdiv <= TIMER_DIV_RST;
        end else begin
            if (wr_tdiv) begin
                tdiv <= Bus_wdata;
                pre  <= '0;
            end else if (tick) begin
                pre  <= '0;
            end else begin
                pre  <= pre + 32'd1;
            end

            if (wr_tcnt)   tcnt <= Bus_wdata;
            else if (tick) tcnt <= tcnt + 32'd1;
        end
    end

    // Two-flop synchronizers for the asynchronous board inputs.
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            sw_meta  <= '0;
            sw_sync  <= '0;
            btn_meta <= '0;
            btn_sync <= '0;
        end else begin
            sw_meta  <= sw;
            sw_sync  <= sw_meta;
            btn_meta <= btn;
            btn_sync <= btn_meta;
        end
    end

    always_comb begin
        periph_rdata = '0;
        unique case (off)
            OFF_SEG:  periph_rdata = seg_data;
            OFF_TCNT: periph_rdata = tcnt;
            OFF_TDIV: periph_rdata = tdiv;
            OFF_LED:  periph_rdata = {8'h00, led};
            OFF_SW:   periph_rdata = {8'h00, sw_sync};
            OFF_BTN:  periph_rdata = {27'h0, btn_sync};
            default:  periph_rdata = '0;
        endcase
    end

    assign Bus_rdata = periph_hit ? periph_rdata : dram_rdata;

endmodule

// File: tb/tb_bus_bridge.sv
module tb_bus_bridge;

    localparam logic [31:0] DIV_RST = 32'd0;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic [31:0] Bus_addr;
    logic        Bus_wen;
    logic [31:0] Bus_wdata;
    logic [31:0] Bus_rdata;
    logic [13:0] dram_addr;
    logic        dram_wen;
    logic [31:0] dram_wdata;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  btn;
    logic [23:0] led;
    logic [31:0] seg_data;

    bus_bridge #(.TIMER_DIV_RST(DIV_RST)) dut (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .Bus_addr  (Bus_addr),
        .Bus_wen   (Bus_wen),
        .Bus_wdata (Bus_wdata),
        .Bus_rdata (Bus_rdata),
        .dram_addr (dram_addr),
        .dram_wen  (dram_wen),
        .dram_wdata(dram_wdata),
        .dram_rdata(dram_rdata),
        .sw        (sw),
        .btn       (btn),
        .led       (led),
        .seg_data  (seg_data)
    );

    always #5 cpu_clk = ~cpu_clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: register images plus a closed-form timer that counts
    // ticks as multiples of the divisor since the last prescaler restart.
    logic [23:0] m_led;
    logic [31:0] m_seg;
    logic [31:0] m_tdiv;
    longint      m_base, m_base_edge, m_anchor;
    longint      ecount = 0;
    longint      rst_edge = 0;
    logic [23:0] sw_s  [0:8191];
    logic [4:0]  btn_s [0:8191];

    logic        rst_drive;
    logic [23:0] sw_drive;
    logic [4:0]  btn_drive;
    logic [31:0] last_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic longint ticks_upto(input longint e);
        longint d;
        d = (m_tdiv == 32'd0) ? 64'sd1 : longint'(m_tdiv);
        if (e <= m_anchor) return 0;
        return (e - m_anchor) / d;
    endfunction

    function automatic logic [31:0] tcnt_at(input longint e);
        longint v;
        v = m_base + ticks_upto(e) - ticks_upto(m_base_edge);
        return v[31:0];
    endfunction

    function automatic logic [23:0] sw_sync_now();
        if (ecount - 1 > rst_edge) return sw_s[int'(ecount - 1)];
        return '0;
    endfunction

    function automatic logic [4:0] btn_sync_now();
        if (ecount - 1 > rst_edge) return btn_s[int'(ecount - 1)];
        return '0;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a[31:12] != 20'hFFFFF) return dram_rdata;
        case (a[11:0])
            12'h000: return m_seg;
            12'h020: return tcnt_at(ecount);
            12'h024: return m_tdiv;
            12'h060: return {8'h00, m_led};
            12'h070: return {8'h00, sw_sync_now()};
            12'h078: return {27'h0, btn_sync_now()};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_led       = '0;
        m_seg       = '0;
        m_tdiv      = DIV_RST;
        m_base      = 0;
        m_base_edge = ecount;
        m_anchor    = ecount;
        rst_edge    = ecount;
    endtask

    task automatic edge_step(input logic [31:0] a, input logic wen, input logic [31:0] wd);
        @(posedge cpu_clk);
        ecount++;
        sw_s[int'(ecount)]  = sw;
        btn_s[int'(ecount)] = btn;
        if (!cpu_rst) begin
            model_reset();
        end else if (wen && a[31:12] == 20'hFFFFF) begin
            case (a[11:0])
                12'h000: m_seg = wd;
                12'h020: begin
                    m_base      = longint'(wd);
                    m_base_edge = ecount;
                end
                12'h024: begin
                    m_base      = longint'(tcnt_at(ecount));
                    m_base_edge = ecount;
                    m_anchor    = ecount;
                    m_tdiv      = wd;
                end
                12'h060: m_led = wd[23:0];
                default: ;
            endcase
        end
    endtask

    task automatic bus_op(input logic [31:0] a, input logic wen, input logic [31:0] wd);
        logic periph;
        @(negedge cpu_clk);
        cpu_rst    = rst_drive;
        sw         = sw_drive;
        btn        = btn_drive;
        Bus_addr   = a;
        Bus_wen    = wen;
        Bus_wdata  = wd;
        dram_rdata = $urandom;
        if (!rst_drive) model_reset();
        #1;
        periph = (a[31:12] == 20'hFFFFF);
        check("dram_addr", {18'h0, dram_addr}, {18'h0, a[15:2]});
        check("dram_wen", {31'h0, dram_wen}, {31'h0, wen & ~periph});
        check("dram_wdata", dram_wdata, wd);
        check("rdata", Bus_rdata, exp_read(a));
        check("led", {8'h0, led}, {8'h0, m_led});
        check("seg_data", seg_data, m_seg);
        last_rdata = Bus_rdata;
        edge_step(a, wen, wd);
    endtask

    task automatic async_reset_pulse();
        @(negedge cpu_clk);
        Bus_addr = 32'hFFFF_F020;
        Bus_wen  = 1'b0;
        #1;
        cpu_rst = 1'b0;
        model_reset();
        #1;
        check("async_led", {8'h0, led}, 32'h0);
        check("async_tcnt", Bus_rdata, 32'h0);
        Bus_addr = 32'hFFFF_F0FC;
        #1;
        check("async_unmapped", Bus_rdata, 32'h0);
        cpu_rst = 1'b1;
        rst_drive = 1'b1;
        edge_step(Bus_addr, 1'b0, 32'h0);
    endtask

    localparam int N_OFF = 9;
    logic [11:0] off_tab [0:N_OFF-1] = '{12'h000, 12'h020, 12'h024, 12'h060,
                                         12'h070, 12'h078, 12'h0FC, 12'h004, 12'hF00};

    initial begin
        logic [31:0] a, wd;
        logic        wen;
        cpu_rst = 1'b0; Bus_addr = '0; Bus_wen = 1'b0; Bus_wdata = '0;
        dram_rdata = '0; sw = '0; btn = '0;
        rst_drive = 1'b0; sw_drive = '0; btn_drive = '0;
        model_reset();

        // Reset state
        bus_op(32'hFFFF_F060, 1'b0, '0);
        bus_op(32'hFFFF_F020, 1'b0, '0);
        bus_op(32'hFFFF_F024, 1'b0, '0);
        check("rst_tdiv", last_rdata, DIV_RST);
        bus_op(32'h0000_0040, 1'b1, 32'h1111_2222);
        rst_drive = 1'b1;

        // DRAM path
        bus_op(32'h0000_1234, 1'b1, 32'hDEAD_BEEF);
        check("dram_addr_const", {18'h0, dram_addr}, 32'h0000_048D);
        bus_op(32'h0000_1234, 1'b0, 32'h0);
        check("dram_wen_after", {31'h0, dram_wen}, 32'h0);

        // Peripheral write isolation
        bus_op(32'hFFFF_F060, 1'b1, 32'h00AB_CDEF);
        bus_op(32'hFFFF_F060, 1'b0, 32'h0);
        check("led_readback", last_rdata, 32'h00AB_CDEF);
        check("led_out", {8'h0, led}, 32'h00AB_CDEF);
        bus_op(32'hFFFF_F070, 1'b1, 32'hFFFF_FFFF);
        bus_op(32'hFFFF_F000, 1'b1, 32'h1234_5678);

        // Switch synchronizer
        for (int i = 0; i < 3; i++) bus_op(32'hFFFF_F070, 1'b0, '0);
        sw_drive = 24'h5A5A5A;
        bus_op(32'hFFFF_F070, 1'b0, '0);
        bus_op(32'hFFFF_F070, 1'b0, '0);
        check("sw_old", last_rdata, 32'h0);
        bus_op(32'hFFFF_F070, 1'b0, '0);
        check("sw_new", last_rdata, 32'h005A_5A5A);

        // Timer divide
        bus_op(32'hFFFF_F024, 1'b1, 32'd4);
        bus_op(32'hFFFF_F020, 1'b1, 32'd0);
        for (int i = 0; i < 20; i++) bus_op(32'hFFFF_F020, 1'b0, '0);
        bus_op(32'hFFFF_F020, 1'b0, '0);
        check("tdiv4_tcnt", last_rdata, 32'd5);

        // Wrap
        bus_op(32'hFFFF_F024, 1'b1, 32'd1);
        bus_op(32'hFFFF_F020, 1'b1, 32'hFFFF_FFFF);
        bus_op(32'hFFFF_F020, 1'b0, '0);
        check("wrap_pre", last_rdata, 32'hFFFF_FFFF);
        bus_op(32'hFFFF_F020, 1'b0, '0);
        check("wrap", last_rdata, 32'h0);

        // Write/tick collision
        bus_op(32'hFFFF_F020, 1'b1, 32'd100);
        bus_op(32'hFFFF_F020, 1'b0, '0);
        check("coll_100", last_rdata, 32'd100);
        bus_op(32'hFFFF_F020, 1'b0, '0);
        check("coll_101", last_rdata, 32'd101);

        // Async reset mid-operation
        bus_op(32'hFFFF_F060, 1'b1, 32'h00FF_FFFF);
        bus_op(32'hFFFF_F024, 1'b1, 32'd1000);
        bus_op(32'hFFFF_F020, 1'b1, 32'd37);
        bus_op(32'hFFFF_F020, 1'b0, '0);
        check("pre_reset_tcnt", last_rdata, 32'd37);
        async_reset_pulse();
        for (int i = 0; i < 4; i++) bus_op(32'hFFFF_F020, 1'b0, '0);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) sw_drive  = 24'($urandom);
            if ($urandom_range(0, 3) == 0) btn_drive = 5'($urandom);
            if ($urandom_range(0, 199) == 0) begin
                async_reset_pulse();
            end else begin
                wd  = $urandom;
                wen = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 9) < 3) begin
                    a = $urandom;
                    if (a[31:12] == 20'hFFFFF) a[31] = 1'b0;
                end else begin
                    a = {20'hFFFFF, off_tab[$urandom_range(0, N_OFF - 1)]};
                    if (a[11:0] == 12'h024) wd = $urandom_range(0, 6);
                    if (a[11:0] == 12'h020 && $urandom_range(0, 3) == 0)
                        wd = 32'hFFFF_FFF0 + $urandom_range(0, 15);
                end
                bus_op(a, wen, wd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
